// File: rtl/final_unit.sv
// final_unit: accumulates accepted samples modulo 2^WIDTH until finalized, then holds the result until reset.
// Define FINAL_UNIT_COUNT_EN to add a saturating 32-bit accepted-sample counter port.
module final_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             valid,
    input  logic             fin,
    output logic [WIDTH-1:0] x,
    output logic             done
`ifdef FINAL_UNIT_COUNT_EN
    ,
    output logic [31:0]      count
`endif
);
    typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (state_q == RUN) begin
            acc_d   = valid ? acc_q + a : acc_q;
            state_d = fin ? DONE : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end
    // One-bit state encoding makes done a direct flop output.
    assign x    = acc_q;
    assign done = state_q;
`ifdef FINAL_UNIT_COUNT_EN
    logic [31:0] count_q, count_d;
    always_comb begin
        count_d = count_q;
        if (state_q == RUN && valid && count_q != 32'hFFFF_FFFF)
            count_d = count_q + 32'd1;
    end
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end
    assign count = count_q;
`endif
endmodule

// File: tb/tb_final_unit.sv
// tb_final_unit: randomized and directed checks of final_unit against a sum-based reference model.
module tb_final_unit;
    localparam int W = 64;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [W-1:0] a = '0;
    logic valid = 1'b0;
    logic fin = 1'b0;
    logic [W-1:0] x;
    logic done;
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] m_acc;
    logic m_done;
    longint unsigned m_cnt;
`ifdef FINAL_UNIT_COUNT_EN
    logic [31:0] count;
`endif

    final_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .valid(valid),
        .fin(fin),
        .x(x),
        .done(done)
`ifdef FINAL_UNIT_COUNT_EN
        ,
        .count(count)
`endif
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, and leave time 1 unit after the edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic f);
        @(negedge clk);
        rst = r;
        valid = v;
        a = d;
        fin = f;
        @(posedge clk);
        if (r) begin
            m_acc = '0;
            m_done = 1'b0;
            m_cnt = 0;
        end else if (!m_done) begin
            if (v) begin
                m_acc = m_acc + d;
                if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
            if (f) m_done = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 64'd77, 1'b1);
        n_checks++;
        if (x !== '0) begin n_errors++; $display("FAIL reset_x got=%h want=0", x); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b want=0", done); end
`ifdef FINAL_UNIT_COUNT_EN
        n_checks++;
        if (count !== 32'd0) begin n_errors++; $display("FAIL reset_count got=%0d want=0", count); end
`endif
    endtask

    task automatic test_basic_sum();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 64'd5, 1'b0);
        n_checks++;
        if (x !== 64'd5) begin n_errors++; $display("FAIL sum_first got=%0d want=5", x); end
        step(1'b0, 1'b1, 64'd7, 1'b0);
        n_checks++;
        if (x !== 64'd12) begin n_errors++; $display("FAIL sum_second got=%0d want=12", x); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL sum_done got=%b want=0", done); end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, {W{1'b1}}, 1'b0);
        step(1'b0, 1'b1, 64'd2, 1'b0);
        n_checks++;
        if (x !== 64'd1) begin n_errors++; $display("FAIL wrap_x got=%h want=1", x); end
`ifdef FINAL_UNIT_COUNT_EN
        n_checks++;
        if (count !== 32'd2) begin n_errors++; $display("FAIL wrap_count got=%0d want=2", count); end
`endif
    endtask

    task automatic test_valid_fin();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 64'd10, 1'b0);
        step(1'b0, 1'b1, 64'd3, 1'b1);
        n_checks++;
        if (x !== 64'd13) begin n_errors++; $display("FAIL vf_x got=%0d want=13", x); end
        n_checks++;
        if (done !== 1'b1) begin n_errors++; $display("FAIL vf_done got=%b want=1", done); end
        step(1'b0, 1'b1, 64'd100, 1'b0);
        n_checks++;
        if (x !== 64'd13) begin n_errors++; $display("FAIL vf_hold got=%0d want=13", x); end
`ifdef FINAL_UNIT_COUNT_EN
        n_checks++;
        if (count !== 32'd2) begin n_errors++; $display("FAIL vf_count got=%0d want=2", count); end
`endif
    endtask

    task automatic test_reset_priority();
        step(1'b1, 1'b1, 64'd9, 1'b0);
        n_checks++;
        if (x !== '0) begin n_errors++; $display("FAIL rp_x got=%0d want=0", x); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL rp_done got=%b want=0", done); end
        step(1'b0, 1'b1, 64'd9, 1'b0);
        n_checks++;
        if (x !== 64'd9) begin n_errors++; $display("FAIL rp_after got=%0d want=9", x); end
    endtask

    task automatic test_fin_no_valid();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 64'd4, 1'b0);
        step(1'b0, 1'b0, 64'd50, 1'b1);
        n_checks++;
        if (x !== 64'd4 || done !== 1'b1) begin
            n_errors++; $display("FAIL fnv got x=%0d done=%b want x=4 done=1", x, done);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 64'd1, 1'b1);
            n_checks++;
            if (x !== 64'd4 || done !== 1'b1) begin
                n_errors++; $display("FAIL fnv_refin got x=%0d done=%b want x=4 done=1", x, done);
            end
        end
    endtask

    task automatic test_idle_hold();
        logic [W-1:0] held;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 64'd31, 1'b0);
        held = 64'd31;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, {$urandom(), $urandom()}, 1'b0);
            n_checks++;
            if (x !== held || done !== 1'b0) begin
                n_errors++; $display("FAIL idle cyc=%0d got x=%0d done=%b want x=%0d done=0", i, x, done, held);
            end
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                 {$urandom(), $urandom()}, $urandom_range(0, 29) == 0);
            n_checks++;
            if (x !== m_acc || done !== m_done) begin
                n_errors++; $display("FAIL rand cyc=%0d got x=%h done=%b want x=%h done=%b", i, x, done, m_acc, m_done);
            end
`ifdef FINAL_UNIT_COUNT_EN
            n_checks++;
            if (count !== m_cnt[31:0]) begin
                n_errors++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", i, count, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        m_acc = '0;
        m_done = 1'b0;
        m_cnt = 0;
        test_reset();
        test_basic_sum();
        test_wrap();
        test_valid_fin();
        test_reset_priority();
        test_fin_no_valid();
        test_idle_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/final_unit.md
FINAL_UNIT -- requirements
Module: final_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width of input a and output x.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port a  input  WIDTH  sample data.
REQ-005 SHALL have port valid  input  1  a is accepted on this edge when high.
REQ-006 SHALL have port fin  input  1  finalize request.
REQ-007 SHALL have port x  output  WIDTH  registered accumulated result.
REQ-008 SHALL have port done  output  1  high once finalized.
REQ-009 All outputs SHALL be driven directly from flops, with no combinational path from any input.

Function
REQ-010 SHALL implement two states, RUN and DONE.
REQ-011 In RUN, each edge with valid=1 SHALL update acc <= acc + a, modulo 2^WIDTH, with silent wrap-around and no carry-out.
REQ-012 x SHALL equal acc.
  - Latency: one cycle from the accepting edge to x.
  - x SHALL hold its value on cycles with valid=0.
REQ-013 In RUN, an edge with fin=1 SHALL move the block to DONE.
  - done SHALL rise on that same edge.
  - If valid=1 on that edge, that sample SHALL be included in the final x.
REQ-014 In DONE, valid and fin SHALL be ignored.
  - x and done SHALL stay constant until rst.
REQ-015 fin=1 while already in DONE SHALL have no effect.
REQ-016 The x value at the first cycle with done=1 SHALL be the final result.
  - It equals the wrapped sum of all samples accepted since the last reset.

Reset
REQ-017 rst=1 on an edge SHALL force RUN, acc=0, x=0 and done=0.
REQ-018 rst SHALL take priority over valid and fin on the same edge.
REQ-019 rst asserted mid-operation or in DONE SHALL discard all accumulated state.
REQ-020 Outputs SHALL be undefined before the first reset edge.
  - Benches SHALL assert rst for at least 1 cycle at start.

Configuration
REQ-021 With macro FINAL_UNIT_COUNT_EN defined, the module SHALL add port count  output  32  number of accepted samples since reset.
  - count resets to 0.
  - count increments on each accepted sample, with the same rules as acc.
  - count saturates at 0xFFFFFFFF.
  - count freezes in DONE.
REQ-022 Without FINAL_UNIT_COUNT_EN, the count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-023 Basic sum: rst; then valid=1 with a=5, then a=7 -> x=5 after the first edge, x=12 after the second, done=0.
REQ-024 Wrap-around: a=0xFFFF_FFFF_FFFF_FFFF, then a=2 -> x=1 (count=2 when enabled).
REQ-025 Simultaneous valid+fin: acc=10, a=3, valid=1, fin=1 -> x=13 and done=1 next cycle; further a=100 with valid=1 leaves x=13.
REQ-026 Finalize with no valid: acc=4, fin=1, valid=0 -> x=4 and done=1; subsequent fin=1 changes nothing.
REQ-027 Reset priority: in DONE with x=13, rst=1 together with valid=1 and a=9 -> x=0, done=0 next cycle; then a=9 with valid=1 -> x=9.
REQ-028 Idle hold: in RUN, valid=0 for 20 cycles -> x unchanged and done=0 throughout.
